// File: rtl/audio_nios_pio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : audio_nios_pio_ctrl
//  Purpose  : Avalon-MM slave general-purpose I/O block for the audio Nios
//             subsystem (I2C SCL/SDA, codec control lines, pushbuttons).
//             Provides an output data register, per-bit direction, an input
//             synchronizer, edge capture with write-one-to-clear, a maskable
//             level interrupt, and atomic OUTSET/OUTCLR registers.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1           system clock
//    reset_n    in   1           asynchronous active-low reset
//    address    in   3           register word select
//    chipselect in   1           slave select
//    write_n    in   1           active-low write strobe
//    writedata  in   32          write data (low DATA_WIDTH bits used)
//    readdata   out  32          read data, combinational, zero wait states
//    pio_in     in   DATA_WIDTH  pin inputs, asynchronous to clk
//    pio_out    out  DATA_WIDTH  output data register
//    pio_oe     out  DATA_WIDTH  per-bit output enable (direction register)
//    irq        out  1           level interrupt
//
//  Register map (word address)
//    0 DATA    W: data_out        R: synchronized pin inputs
//    1 DIR     R/W (1 = output)
//    2 IRQMASK R/W
//    3 EDGECAP R: captured edges  W: write-one-to-clear
//    4 OUTSET  W: data_out |= wd  R: 0
//    5 OUTCLR  W: data_out &= ~wd R: 0
//    6,7       reserved, writes ignored, read 0
//
//  Parameters
//    DATA_WIDTH  1..32 pin count
//    OUT_RESET   reset value of data_out
//    DIR_RESET   reset value of dir
//    EDGE_TYPE   0 rising, 1 falling, 2 any edge
//    SYNC_STAGES 2..4 synchronizer depth
// ============================================================================
module audio_nios_pio_ctrl #(
    parameter int          DATA_WIDTH  = 8,
    parameter logic [31:0] OUT_RESET   = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] pio_in,
    output logic [DATA_WIDTH-1:0] pio_out,
    output logic [DATA_WIDTH-1:0] pio_oe,
    output logic                  irq
);

    localparam logic [2:0] c_ADDR_DATA    = 3'd0;
    localparam logic [2:0] c_ADDR_DIR     = 3'd1;
    localparam logic [2:0] c_ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] c_ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] c_ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] c_ADDR_OUTCLR  = 3'd5;

    localparam logic [DATA_WIDTH-1:0] c_OUT_RST = OUT_RESET[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] c_DIR_RST = DIR_RESET[DATA_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] dir_q,      dir_d;
    logic [DATA_WIDTH-1:0] irqmask_q,  irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q,  edgecap_d;
    logic [DATA_WIDTH-1:0] prev_in_q,  prev_in_d;
    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] sync_d [SYNC_STAGES];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_sync_in;
    logic [DATA_WIDTH-1:0] w_rise;
    logic [DATA_WIDTH-1:0] w_fall;
    logic [DATA_WIDTH-1:0] w_det;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] w_rd_val;

    assign w_wr    = chipselect & ~write_n;
    assign w_wdata = writedata[DATA_WIDTH-1:0];

    // Upper write-data bits carry no meaning for narrow configurations.
    generate
        if (DATA_WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Input synchronizer: stage 0 samples the raw pins, the last stage is
    // the value seen by firmware and by the edge detector.
    // ------------------------------------------------------------------------
    always_comb begin
        sync_d[0] = pio_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign w_sync_in = sync_q[SYNC_STAGES-1];
    assign prev_in_d = w_sync_in;

    // ------------------------------------------------------------------------
    // Edge detect
    // ------------------------------------------------------------------------
    assign w_rise = w_sync_in & ~prev_in_q;
    assign w_fall = ~w_sync_in & prev_in_q;

    always_comb begin
        case (EDGE_TYPE)
            0:       w_det = w_rise;
            1:       w_det = w_fall;
            default: w_det = w_rise | w_fall;
        endcase
    end

    // ------------------------------------------------------------------------
    // Register write decode and edge-capture next state
    // ------------------------------------------------------------------------
    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irqmask_d  = irqmask_q;
        w_clr      = '0;
        if (w_wr) begin
            case (address)
                c_ADDR_DATA:    data_out_d = w_wdata;
                c_ADDR_DIR:     dir_d      = w_wdata;
                c_ADDR_IRQMASK: irqmask_d  = w_wdata;
                c_ADDR_EDGECAP: w_clr      = w_wdata;
                c_ADDR_OUTSET:  data_out_d = data_out_q | w_wdata;
                c_ADDR_OUTCLR:  data_out_d = data_out_q & ~w_wdata;
                default:        ;
            endcase
        end
        // A fresh edge is OR-ed in after the clear so it is never lost to a
        // clear issued in the same cycle.
        edgecap_d = (edgecap_q & ~w_clr) | w_det;
    end

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= c_OUT_RST;
            dir_q      <= c_DIR_RST;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            prev_in_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            prev_in_q  <= prev_in_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read mux: side-effect free, upper bits always zero
    // ------------------------------------------------------------------------
    always_comb begin
        case (address)
            c_ADDR_DATA:    w_rd_val = w_sync_in;
            c_ADDR_DIR:     w_rd_val = dir_q;
            c_ADDR_IRQMASK: w_rd_val = irqmask_q;
            c_ADDR_EDGECAP: w_rd_val = edgecap_q;
            default:        w_rd_val = '0;
        endcase
        readdata                 = '0;
        readdata[DATA_WIDTH-1:0] = w_rd_val;
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign pio_out = data_out_q;
    assign pio_oe  = dir_q;
    assign irq     = |(edgecap_q & irqmask_q);

endmodule
`default_nettype wire

// File: tb/tb_audio_nios_pio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_nios_pio_ctrl
//  Purpose  : Self-checking bench for audio_nios_pio_ctrl. Two instances share
//             the bus and pins: u_dut_r (rising-edge capture) and u_dut_a
//             (any-edge capture), both DATA_WIDTH=8, OUT_RESET=A5,
//             DIR_RESET=0F, SYNC_STAGES=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_nios_pio_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  pio_in;

    logic [31:0] rd_r, rd_a;
    logic [7:0]  out_r, out_a, oe_r, oe_a;
    logic        irq_r, irq_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    audio_nios_pio_ctrl #(
        .DATA_WIDTH (8),
        .OUT_RESET  (32'hA5),
        .DIR_RESET  (32'h0F),
        .EDGE_TYPE  (0),
        .SYNC_STAGES(2)
    ) u_dut_r (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (rd_r),
        .pio_in    (pio_in),
        .pio_out   (out_r),
        .pio_oe    (oe_r),
        .irq       (irq_r)
    );

    audio_nios_pio_ctrl #(
        .DATA_WIDTH (8),
        .OUT_RESET  (32'hA5),
        .DIR_RESET  (32'h0F),
        .EDGE_TYPE  (2),
        .SYNC_STAGES(2)
    ) u_dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (rd_a),
        .pio_in    (pio_in),
        .pio_out   (out_a),
        .pio_oe    (oe_a),
        .irq       (irq_a)
    );

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] r0, output logic [31:0] r2);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        r0 = rd_r;
        r2 = rd_a;
        chipselect = 1'b0;
    endtask

    task automatic chk_ec(input string name, input logic [7:0] exp_r, input logic [7:0] exp_a);
        logic [31:0] v0, v2;
        bus_read(3'd3, v0, v2);
        chk({name, "_ec_r"}, v0, {24'h0, exp_r});
        chk({name, "_ec_a"}, v2, {24'h0, exp_a});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v0, v2;

        //            wr    addr  wdata   out    oe     rd       irq
        vecs[0]  = '{1'b0, 3'd3, 32'h00, 8'hA5, 8'h0F, 32'h5A, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 32'h00, 8'hA5, 8'h0F, 32'h5A, 1'b0};
        vecs[2]  = '{1'b1, 3'd0, 32'h3C, 8'h3C, 8'h0F, 32'h5A, 1'b0};
        vecs[3]  = '{1'b1, 3'd4, 32'h81, 8'hBD, 8'h0F, 32'h00, 1'b0};
        vecs[4]  = '{1'b1, 3'd5, 32'h0C, 8'hB1, 8'h0F, 32'h00, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 32'hF0, 8'hB1, 8'hF0, 32'hF0, 1'b0};
        vecs[6]  = '{1'b1, 3'd6, 32'hFF, 8'hB1, 8'hF0, 32'h00, 1'b0};
        vecs[7]  = '{1'b1, 3'd7, 32'hFF, 8'hB1, 8'hF0, 32'h00, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 32'h0C, 8'hB1, 8'hF0, 32'h0C, 1'b1};
        vecs[9]  = '{1'b1, 3'd3, 32'hFF, 8'hB1, 8'hF0, 32'h00, 1'b0};
        vecs[10] = '{1'b1, 3'd2, 32'h00, 8'hB1, 8'hF0, 32'h00, 1'b0};

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        pio_in     = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_out", {24'h0, out_r}, 32'hA5);
        chk("rst_oe",  {24'h0, oe_r},  32'h0F);
        chk("rst_irq", {31'h0, irq_r}, 32'h0);
        reset_n = 1'b1;
        tick();
        bus_read(3'd2, v0, v2);
        chk("rst_rd2", v0, 32'h0);
        bus_read(3'd3, v0, v2);
        chk("rst_rd3", v0, 32'h0);

        // Present a pattern on the pins; rising bits get captured by both.
        pio_in = 8'h5A;
        repeat (5) tick();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, v0, v2);
            chk($sformatf("vec%0d_out_r", i), {24'h0, out_r}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_out_a", i), {24'h0, out_a}, {24'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d_oe", i),    {24'h0, oe_r},  {24'h0, vecs[i].exp_oe});
            chk($sformatf("vec%0d_rd_r", i),  v0, vecs[i].exp_rd);
            chk($sformatf("vec%0d_rd_a", i),  v2, vecs[i].exp_rd);
            chk($sformatf("vec%0d_irq", i),   {31'h0, irq_r}, {31'h0, vecs[i].exp_irq});
        end

        // Rising edge on bit2: captured exactly three clocks after the change.
        bus_write(3'd2, 32'h04);
        pio_in = 8'h5E;
        tick();
        tick();
        chk_ec("lat2", 8'h00, 8'h00);
        chk("lat2_irq", {31'h0, irq_r}, 32'h0);
        tick();
        chk_ec("lat3", 8'h04, 8'h04);
        chk("lat3_irq_r", {31'h0, irq_r}, 32'h1);
        chk("lat3_irq_a", {31'h0, irq_a}, 32'h1);
        pio_in = 8'h5A;
        repeat (5) tick();
        chk_ec("fall_b2", 8'h04, 8'h04);
        bus_write(3'd3, 32'h04);
        chk_ec("clr_b2", 8'h00, 8'h00);
        chk("clr_b2_irq", {31'h0, irq_r}, 32'h0);

        // Three-clock pulse on bit0, then W1C.
        bus_write(3'd2, 32'h01);
        pio_in = 8'h5B;
        repeat (3) tick();
        pio_in = 8'h5A;
        repeat (5) tick();
        chk_ec("pulse", 8'h01, 8'h01);
        chk("pulse_irq_a", {31'h0, irq_a}, 32'h1);
        bus_write(3'd3, 32'h01);
        chk_ec("pulse_clr", 8'h00, 8'h00);
        chk("pulse_clr_irq", {31'h0, irq_a}, 32'h0);

        // Falling edge alone: only the any-edge instance captures.
        pio_in = 8'h5B;
        repeat (5) tick();
        bus_write(3'd3, 32'h01);
        chk_ec("fall_pre", 8'h00, 8'h00);
        pio_in = 8'h5A;
        repeat (5) tick();
        chk_ec("fall_only", 8'h00, 8'h01);
        chk("fall_irq_r", {31'h0, irq_r}, 32'h0);
        chk("fall_irq_a", {31'h0, irq_a}, 32'h1);
        bus_write(3'd3, 32'h01);

        // W1C of bit5 landing on the same edge as a new bit5 capture.
        bus_write(3'd2, 32'h20);
        pio_in = 8'h7A;
        repeat (5) tick();
        chk_ec("b5_set", 8'h20, 8'h20);
        pio_in = 8'h5A;
        repeat (5) tick();
        pio_in = 8'h7A;
        tick();
        tick();
        bus_write(3'd3, 32'h20);
        chk_ec("collide", 8'h20, 8'h20);
        chk("collide_irq_r", {31'h0, irq_r}, 32'h1);
        chk("collide_irq_a", {31'h0, irq_a}, 32'h1);
        bus_write(3'd3, 32'h20);
        chk_ec("collide_clr", 8'h00, 8'h00);

        // Asynchronous reset in the middle of activity.
        bus_write(3'd0, 32'h55);
        pio_in = 8'h00;
        repeat (4) tick();
        bus_write(3'd3, 32'hFF);
        pio_in = 8'hFF;
        repeat (4) tick();
        chk_ec("all_set", 8'hFF, 8'hFF);
        bus_write(3'd2, 32'hFF);
        chk("pre_rst_out", {24'h0, out_r}, 32'h55);
        chk("pre_rst_irq", {31'h0, irq_r}, 32'h1);
        pio_in = 8'h00;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_out_r", {24'h0, out_r}, 32'hA5);
        chk("arst_out_a", {24'h0, out_a}, 32'hA5);
        chk("arst_oe",    {24'h0, oe_r},  32'h0F);
        chk("arst_irq_r", {31'h0, irq_r}, 32'h0);
        chk("arst_irq_a", {31'h0, irq_a}, 32'h0);
        bus_read(3'd3, v0, v2);
        chk("arst_ec_r", v0, 32'h0);
        chk("arst_ec_a", v2, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        chk_ec("post_rst", 8'h00, 8'h00);
        bus_read(3'd0, v0, v2);
        chk("post_rst_data", v0, 32'h0);
        chk("post_rst_out", {24'h0, out_r}, 32'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
